// File: rtl/tx_frame_packer.sv
// Frame packer: wraps words from a latency-1 upstream FIFO into preamble/header/payload
// frames with idle-timeout padding, or forwards them untouched in bypass mode.
module tx_frame_packer #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       PREAMBLE_LEN = 4,
  parameter logic [DATA_W-1:0] PREAMBLE_VAL = DATA_W'(8'hA5),
  parameter int unsigned       PAYLOAD_LEN  = 64,
  parameter logic [DATA_W-1:0] PAD_VAL      = '0,
  parameter int unsigned       IDLE_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_on,
  input  logic              i_header_on,
  input  logic [DATA_W-1:0] i_fifo_in_data,
  input  logic              i_fifo_in_empty,
  output logic              o_fifo_in_re,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_out_valid,
  input  logic              i_data_out_ready,
  output logic              o_data_out_sof,
  output logic              o_data_out_eof,
  output logic [15:0]       o_frame_cnt,
  output logic              o_pad_event
);

  localparam int unsigned PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam int unsigned PAY_W = $clog2(PAYLOAD_LEN + 1);
  localparam int unsigned IDL_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
  localparam logic [PAY_W-1:0] PAY_LAST = PAY_W'(PAYLOAD_LEN - 1);
  localparam logic [PAY_W-1:0] PAY_FULL = PAY_W'(PAYLOAD_LEN);
  localparam logic [IDL_W-1:0] IDL_LAST = IDL_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StPreamble, StHeader, StPayload, StPad, StBypass
  } state_e;

  state_e            r_state;
  logic              r_hdr_on;
  logic [PRE_W-1:0]  r_pre_cnt;
  logic [PAY_W-1:0]  r_pay_cnt;
  logic [PAY_W-1:0]  r_rd_cnt;
  logic [IDL_W-1:0]  r_idle_cnt;
  logic              r_inflight;
  logic [15:0]       r_frame_cnt;
  logic              r_pad_event;

  logic [DATA_W-1:0] r_buf_data [2];
  logic              r_buf_sof  [2];
  logic              r_buf_eof  [2];
  logic [1:0]        r_buf_cnt;

  logic              w_xfer, w_space, w_wr_idx;
  logic              w_gen_push, w_gen_sof, w_gen_eof;
  logic [DATA_W-1:0] w_gen_data, w_hdr;
  logic              w_rd_want, w_re, w_occ_ok;
  logic [2:0]        w_occ;
  logic              w_push, w_push_sof, w_push_eof;
  logic [DATA_W-1:0] w_push_data;
  logic              w_idle_tick, w_to_fire;

  if (DATA_W > 16) begin : g_hdr_wide
    assign w_hdr = {{(DATA_W-16){1'b0}}, r_frame_cnt};
  end else begin : g_hdr_narrow
    assign w_hdr = r_frame_cnt[DATA_W-1:0];
  end

  assign o_data_out       = r_buf_data[0];
  assign o_data_out_valid = (r_buf_cnt != 2'd0);
  assign o_data_out_sof   = r_buf_sof[0] & o_data_out_valid;
  assign o_data_out_eof   = r_buf_eof[0] & o_data_out_valid;
  assign o_frame_cnt      = r_frame_cnt;
  assign o_pad_event      = r_pad_event;
  assign o_fifo_in_re     = w_re;

  assign w_xfer   = o_data_out_valid & i_data_out_ready;
  assign w_space  = (r_buf_cnt != 2'd2) | w_xfer;
  assign w_wr_idx = (r_buf_cnt == 2'd2) | ((r_buf_cnt == 2'd1) & ~w_xfer);

  // Locally generated words (preamble, header, pad); never coincide with a FIFO arrival.
  always_comb begin
    w_gen_push = 1'b0;
    w_gen_data = '0;
    w_gen_sof  = 1'b0;
    w_gen_eof  = 1'b0;
    case (r_state)
      StPreamble: begin
        w_gen_push = w_space;
        w_gen_data = PREAMBLE_VAL;
        w_gen_sof  = (r_pre_cnt == '0);
      end
      StHeader: begin
        w_gen_push = w_space;
        w_gen_data = w_hdr;
      end
      StPad: begin
        w_gen_push = w_space & (r_pay_cnt != PAY_FULL);
        w_gen_data = PAD_VAL;
        w_gen_eof  = (r_pay_cnt == PAY_LAST);
      end
      default: ;
    endcase
  end

  // The first payload read is issued alongside the last preamble/header word to avoid a bubble.
  always_comb begin
    w_rd_want = 1'b0;
    case (r_state)
      StPreamble: w_rd_want = w_gen_push & (r_pre_cnt == PRE_LAST) & ~r_hdr_on;
      StHeader:   w_rd_want = w_gen_push;
      StPayload:  w_rd_want = (r_rd_cnt != PAY_FULL);
      StBypass:   w_rd_want = ~i_frame_on;
      default:    w_rd_want = 1'b0;
    endcase
  end

  assign w_occ    = {2'b00, r_inflight} + {1'b0, r_buf_cnt} + {2'b00, w_gen_push};
  assign w_occ_ok = (w_occ <= (3'd1 + {2'b00, w_xfer}));
  assign w_re     = w_rd_want & ~i_fifo_in_empty & w_occ_ok;

  assign w_push      = w_gen_push | r_inflight;
  assign w_push_data = r_inflight ? i_fifo_in_data : w_gen_data;
  assign w_push_sof  = r_inflight ? 1'b0 : w_gen_sof;
  assign w_push_eof  = r_inflight ? ((r_state == StPayload) && (r_pay_cnt == PAY_LAST))
                                  : w_gen_eof;

  assign w_idle_tick = (r_state == StPayload) && (r_rd_cnt != PAY_FULL) && i_fifo_in_empty &&
                       !(!i_data_out_ready && (r_buf_cnt == 2'd2));
  assign w_to_fire   = w_idle_tick && (r_idle_cnt == IDL_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_hdr_on    <= 1'b0;
      r_pre_cnt   <= '0;
      r_pay_cnt   <= '0;
      r_rd_cnt    <= '0;
      r_idle_cnt  <= '0;
      r_inflight  <= 1'b0;
      r_frame_cnt <= '0;
      r_pad_event <= 1'b0;
    end else begin
      r_pad_event <= 1'b0;
      r_inflight  <= w_re;
      if (w_re && r_state != StBypass) r_rd_cnt <= r_rd_cnt + PAY_W'(1);
      if ((r_inflight && r_state == StPayload) || (w_gen_push && r_state == StPad)) begin
        r_pay_cnt <= r_pay_cnt + PAY_W'(1);
      end
      if (w_re)             r_idle_cnt <= '0;
      else if (w_idle_tick) r_idle_cnt <= r_idle_cnt + IDL_W'(1);
      if (w_xfer && o_data_out_eof) r_frame_cnt <= r_frame_cnt + 16'd1;

      case (r_state)
        StIdle: begin
          r_hdr_on   <= i_header_on;
          r_pre_cnt  <= '0;
          r_pay_cnt  <= '0;
          r_rd_cnt   <= '0;
          r_idle_cnt <= '0;
          if (!i_frame_on)           r_state <= StBypass;
          else if (!i_fifo_in_empty) r_state <= StPreamble;
        end
        StPreamble: begin
          if (w_gen_push) begin
            r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            if (r_pre_cnt == PRE_LAST) r_state <= r_hdr_on ? StHeader : StPayload;
          end
        end
        StHeader: begin
          if (w_gen_push) r_state <= StPayload;
        end
        StPayload: begin
          if (w_xfer && o_data_out_eof) begin
            r_state <= StIdle;
          end else if (w_to_fire) begin
            // A read in flight lands this cycle and is counted before padding begins.
            r_state     <= StPad;
            r_pad_event <= 1'b1;
            r_idle_cnt  <= '0;
          end
        end
        StPad: begin
          if (w_xfer && o_data_out_eof) r_state <= StIdle;
        end
        StBypass: begin
          if (i_frame_on && !r_inflight && r_buf_cnt == 2'd0) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Two-entry skid buffer; entry 0 drives the output and only moves on a transfer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_sof[0]  <= 1'b0;
      r_buf_sof[1]  <= 1'b0;
      r_buf_eof[0]  <= 1'b0;
      r_buf_eof[1]  <= 1'b0;
      r_buf_cnt     <= 2'd0;
    end else begin
      if (w_xfer) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_sof[0]  <= r_buf_sof[1];
        r_buf_eof[0]  <= r_buf_eof[1];
      end
      if (w_push) begin
        r_buf_data[w_wr_idx] <= w_push_data;
        r_buf_sof[w_wr_idx]  <= w_push_sof;
        r_buf_eof[w_wr_idx]  <= w_push_eof;
      end
      r_buf_cnt <= r_buf_cnt - {1'b0, w_xfer} + {1'b0, w_push};
    end
  end

endmodule

// File: tb/tb_tx_frame_packer.sv
// Scoreboard bench for tx_frame_packer: a frame-level model fills the expected queue,
// a negedge monitor pops and compares every accepted output word.
module tb_tx_frame_packer;

  localparam int unsigned PRE_LEN = 4;
  localparam int unsigned PAY_LEN = 64;
  localparam logic [7:0]  PRE_V   = 8'hA5;
  localparam logic [7:0]  PAD_V   = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_on = 1'b1;
  logic        header_on = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_empty, fifo_re;
  logic [7:0]  dout;
  logic        dvalid, dsof, deof, pad_ev;
  logic [15:0] fcnt;

  always #5 clk = ~clk;

  tx_frame_packer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_frame_on       (frame_on),
    .i_header_on      (header_on),
    .i_fifo_in_data   (fifo_data),
    .i_fifo_in_empty  (fifo_empty),
    .o_fifo_in_re     (fifo_re),
    .o_data_out       (dout),
    .o_data_out_valid (dvalid),
    .i_data_out_ready (ready),
    .o_data_out_sof   (dsof),
    .o_data_out_eof   (deof),
    .o_frame_cnt      (fcnt),
    .o_pad_event      (pad_ev)
  );

  // Upstream FIFO: read data appears one cycle after the RE cycle.
  logic [7:0]  mem [0:4095];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic        flush = 1'b0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_re && !fifo_empty) begin
      fifo_data <= mem[rd_ptr % 4096];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  typedef logic [9:0] ent_t;  // {sof, eof, data}
  ent_t       exp_q[$];
  logic [7:0] ref_src[$];
  int vectors = 0, miscompares = 0;
  int frames_model = 0, pad_events = 0, xfers = 0, run_len = 0, max_run = 0;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom);
      mem[wr_ptr % 4096] = w;
      wr_ptr++;
      ref_src.push_back(w);
    end
  endtask

  // Frame rule: preamble (SOF first), optional header = completed-frame count,
  // then PAY_LEN payload words, short supplies padded with PAD_V, EOF on the last.
  task automatic expect_frame(input bit hdr, input int nwords);
    logic [7:0] w;
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back({(i == 0), 1'b0, PRE_V});
    if (hdr) exp_q.push_back({2'b00, 8'(frames_model)});
    for (int i = 0; i < PAY_LEN; i++) begin
      w = (i < nwords) ? ref_src.pop_front() : PAD_V;
      exp_q.push_back({1'b0, (i == PAY_LEN - 1), w});
    end
    frames_model++;
  endtask

  task automatic expect_bypass(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({2'b00, ref_src.pop_front()});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || dvalid) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0 || dvalid) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout, got %0d words left, want 0", name, exp_q.size());
    end
    step(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    ref_src.delete();
    frames_model = 0;
    step(2);
    flush = 1'b0;
    rst = 1'b0;
    step(2);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // Monitor: samples on the falling edge, between input updates and the next active edge.
  logic prev_stall = 1'b0;
  ent_t prev_ent = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      run_len = 0;
    end else begin
      if (fifo_re) check("re_while_empty", 32'(fifo_empty), 32'(0));
      if (prev_stall) check("stall_hold", 32'({dvalid, dsof, deof, dout}), 32'({1'b1, prev_ent}));
      if (pad_ev) pad_events++;
      if (dvalid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else run_len = 0;
      if (dvalid && ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got 0x%0h, want no word", {dsof, deof, dout});
        end else check("out_word", 32'({dsof, deof, dout}), 32'(exp_q.pop_front()));
      end
      prev_stall = dvalid && !ready;
      prev_ent   = {dsof, deof, dout};
    end
  end

  initial begin
    int target;
    int pads_before;
    bit hdr;
    step(3);
    check("rst_valid", 32'(dvalid), 32'(0));
    check("rst_re", 32'(fifo_re), 32'(0));
    check("rst_sof", 32'(dsof), 32'(0));
    check("rst_eof", 32'(deof), 32'(0));
    check("rst_data", 32'(dout), 32'(0));
    check("rst_fcnt", 32'(fcnt), 32'(0));
    check("rst_pad", 32'(pad_ev), 32'(0));
    rst = 1'b0;
    step(2);

    // Single frame, no header: 68 back-to-back valid words.
    max_run = 0;
    push_words(PAY_LEN);
    expect_frame(1'b0, PAY_LEN);
    wait_drain("basic_frame", 400);
    check("basic_run", 32'(max_run), 32'(PRE_LEN + PAY_LEN));
    check("basic_fcnt", 32'(fcnt), 32'(1));

    // Three header frames from a fresh reset: headers 0, 1, 2.
    do_reset();
    header_on = 1'b1;
    step(1);
    push_words(3 * PAY_LEN);
    for (int f = 0; f < 3; f++) expect_frame(1'b1, PAY_LEN);
    wait_drain("header_frames", 1000);
    check("header_fcnt", 32'(fcnt), 32'(3));

    // Starved payload: 10 words then padding.
    header_on = 1'b0;
    step(1);
    pads_before = pad_events;
    push_words(10);
    expect_frame(1'b0, 10);
    wait_drain("pad_frame", 600);
    check("pad_event_cnt", 32'(pad_events - pads_before), 32'(1));
    check("pad_fcnt", 32'(fcnt), 32'(frames_model));

    // Random backpressure over framed and bypassed traffic.
    rand_ready = 1'b1;
    hdr = 1'($urandom);
    header_on = hdr;
    step(1);
    push_words(3 * PAY_LEN);
    for (int f = 0; f < 3; f++) expect_frame(hdr, PAY_LEN);
    wait_drain("random_frames", 3000);
    check("random_fcnt", 32'(fcnt), 32'(frames_model));
    frame_on = 1'b0;
    step(3);
    push_words(40);
    expect_bypass(40);
    wait_drain("random_bypass", 1000);
    frame_on = 1'b1;
    step(4);
    check("random_bypass_fcnt", 32'(fcnt), 32'(frames_model));
    rand_ready = 1'b0;
    step(2);

    // Framing turned off mid-frame: frame completes, the rest is bypassed.
    header_on = 1'b0;
    step(1);
    push_words(PAY_LEN + 20);
    expect_frame(1'b0, PAY_LEN);
    expect_bypass(20);
    target = xfers + 30;
    for (int n = 0; n < 500 && xfers < target; n++) @(posedge clk);
    #1;
    frame_on = 1'b0;
    wait_drain("mode_switch", 1000);
    frame_on = 1'b1;
    step(4);
    check("mode_fcnt", 32'(fcnt), 32'(frames_model));
    check("total_pad_events", 32'(pad_events), 32'(1));

    // Reset during payload word 20.
    push_words(PAY_LEN);
    expect_frame(1'b0, PAY_LEN);
    target = xfers + PRE_LEN + 19;
    for (int n = 0; n < 500 && xfers < target; n++) @(negedge clk);
    check("reach_word20", 32'(xfers >= target), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(dvalid), 32'(0));
    check("midrst_re", 32'(fifo_re), 32'(0));
    check("midrst_sof_eof", 32'({dsof, deof}), 32'(0));
    check("midrst_data", 32'(dout), 32'(0));
    check("midrst_fcnt", 32'(fcnt), 32'(0));
    check("midrst_pad", 32'(pad_ev), 32'(0));
    do_reset();
    header_on = 1'b1;
    step(1);
    push_words(PAY_LEN);
    expect_frame(1'b1, PAY_LEN);
    wait_drain("after_reset", 400);
    check("after_reset_fcnt", 32'(fcnt), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish within 500us");
    $fatal(1);
  end

endmodule
